ddr4_axi_sync_fifo: RTL and testbench
=====================================

# ddr4_axi_sync_fifo

Parametrised single-clock FIFO for the DDR4 AXI front end, used for command, write-data and response buffering between the AXI slave channels and the memory-controller request path. It generalises the team's shift-register FIFO to arbitrary (non-power-of-two) depth with a circular RAM, programmable almost-full/almost-empty thresholds, an occupancy count, overrun/underrun protection with error pulses, and a selectable first-word-fall-through or registered-output read mode.

## Interface
- C_WIDTH, 8, data width in bits (1..1024)
- C_DEPTH, 16, number of entries (2..256, any integer)
- C_AWIDTH, 4, pointer width; must satisfy 2**C_AWIDTH >= C_DEPTH
- C_AFULL_THRESH, C_DEPTH-2, a_full asserts when count >= this value
- C_AEMPTY_THRESH, 1, a_empty asserts when count <= this value
- C_FWFT, 1, 1 = first-word-fall-through, 0 = registered (standard) read
- clk  in  1  single system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- wr_en  in  1  write request
- din  in  C_WIDTH  write data
- rd_en  in  1  read request
- dout  out  C_WIDTH  read data
- full  out  1  count == C_DEPTH
- a_full  out  1  count >= C_AFULL_THRESH
- empty  out  1  count == 0
- a_empty  out  1  count <= C_AEMPTY_THRESH
- count  out  C_AWIDTH+1  current occupancy, 0..C_DEPTH
- overflow  out  1  one-cycle pulse: a write was rejected
- underflow  out  1  one-cycle pulse: a read was rejected

## Operation
- Storage: C_DEPTH x C_WIDTH array, not reset. Write pointer wr_ptr, read pointer rd_ptr, each 0..C_DEPTH-1, wrapping C_DEPTH-1 -> 0 (not at 2**C_AWIDTH).
- rd_acc = rd_en & !empty. wr_acc = wr_en & (!full | rd_acc); write into a full FIFO is accepted only with a simultaneous accepted read.
- On wr_acc: mem[wr_ptr] <= din, wr_ptr advances. On rd_acc: rd_ptr advances.
- count: +1 on wr_acc & !rd_acc, -1 on rd_acc & !wr_acc, unchanged otherwise. Never leaves 0..C_DEPTH.
- Write into empty FIFO with simultaneous rd_en: write accepted, read rejected (no same-cycle fall-through), underflow pulses.
- full, a_full, empty, a_empty: decoded from the count register only, no input-to-flag combinational path.
- overflow registered: set next cycle iff wr_en & !wr_acc. underflow registered: set next cycle iff rd_en & empty. Each pulse lasts one cycle per offending request.
- C_FWFT=1: dout = mem[rd_ptr] combinationally; value unspecified while empty.
- C_FWFT=0: dout is a register, loaded with mem[rd_ptr] on rd_acc, held otherwise; reset value 0.
- Reset (rst_n low, any time incl. mid-burst): wr_ptr = rd_ptr = 0, count = 0, empty = 1, a_empty = 1, full = a_full = 0, overflow = underflow = 0, registered dout = 0. Requests during reset are ignored; first acceptance on the first rising edge after rst_n is sampled high.

## Timing
- Write latency: word accepted at edge N; count/empty update after edge N; in FWFT mode the word is on dout in cycle N+1.
- Read latency: FWFT 0 cycles (data present before rd_en); standard mode dout valid the cycle after the accepting edge.
- Flags and count change only on clock edges (or asynchronously at reset assertion).
- Full throughput: one write and one read per cycle sustained, including at full and at pointer wrap.

## Structure
- Shared package/header ddr4_axi_fifo_pkg: clog2 function, mode constants C_FWFT_MODE = 1 / C_STD_MODE = 0, parameter range checks.
- One sub-module: ddr4_axi_fifo_ptr (modulo-C_DEPTH wrapping pointer with increment enable and async active-low reset), instantiated for wr_ptr and rd_ptr.
- Storage inferred as distributed RAM; no vendor primitives.

## Test plan
- Reset then fill, C_DEPTH=5, C_FWFT=1: write 0x01..0x05 -> count 1..5, full after 5th, a_full at count 3; read 5 -> dout 0x01..0x05 in order, empty after last.
- Wrap, C_DEPTH=5: 12 interleaved write/read pairs with data 0x10..0x1B -> exact in-order output, count stays <= 1, no error pulses.
- Full with wr_en only -> overflow pulses 1 cycle, count stays 5, contents unchanged; full with wr_en & rd_en -> both accepted, count stays 5, order preserved.
- Empty with rd_en -> underflow pulse, count 0; empty with wr_en & rd_en (din 0xAA) -> count 1, underflow pulse, next read returns 0xAA.
- C_FWFT=0: write 0x33, 0x44; rd_en one cycle -> dout = 0x33 the following cycle, holds until next rd_acc, then 0x44.
- Assert rst_n low mid-burst at count 3 -> immediate empty=1, count=0, dout reg 0; after release, write 0x77 and read -> 0x77 (no stale data).

Source files
------------

// File: rtl/ddr4_axi_fifo_pkg.sv
// Shared definitions for the DDR4 AXI front-end FIFOs: read-mode constants, clog2 and parameter sanity checks.
package ddr4_axi_fifo_pkg;

  localparam int C_FWFT_MODE = 1;
  localparam int C_STD_MODE  = 0;

  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res++;
      rem = rem >> 1;
    end
    return res;
  endfunction

  function automatic bit fifo_params_ok(input int width, input int depth, input int awidth,
                                        input int afull, input int aempty, input int fwft);
    return (width >= 1) && (width <= 1024) &&
           (depth >= 2) && (depth <= 256) &&
           (awidth >= clog2(depth)) &&
           (afull >= 0) && (afull <= depth) &&
           (aempty >= 0) && (aempty <= depth) &&
           ((fwft == C_FWFT_MODE) || (fwft == C_STD_MODE));
  endfunction

endpackage

// File: rtl/ddr4_axi_fifo_ptr.sv
// Modulo-C_DEPTH pointer: advances on inc, wraps C_DEPTH-1 -> 0 (not at the power of two).
// Output is registered; no backpressure, caller qualifies inc.
module ddr4_axi_fifo_ptr #(
  parameter int C_DEPTH  = 16,
  parameter int C_AWIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc,
  output logic [C_AWIDTH-1:0] ptr
);

  localparam logic [C_AWIDTH-1:0] C_LAST = C_AWIDTH'(C_DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == C_LAST) ? '0 : ptr + C_AWIDTH'(1);
    end
  end

endmodule

// File: rtl/ddr4_axi_sync_fifo.sv
// Single-clock circular-RAM FIFO, any depth; write-to-dout 1 cycle (FWFT) / read-to-dout 1 cycle (standard).
// Full rejects writes unless a read is accepted the same cycle; rejected requests pulse overflow/underflow.
module ddr4_axi_sync_fifo
  import ddr4_axi_fifo_pkg::*;
#(
  parameter int C_WIDTH         = 8,
  parameter int C_DEPTH         = 16,
  parameter int C_AWIDTH        = 4,
  parameter int C_AFULL_THRESH  = C_DEPTH - 2,
  parameter int C_AEMPTY_THRESH = 1,
  parameter int C_FWFT          = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [C_WIDTH-1:0]  din,
  input  logic                rd_en,
  output logic [C_WIDTH-1:0]  dout,
  output logic                full,
  output logic                a_full,
  output logic                empty,
  output logic                a_empty,
  output logic [C_AWIDTH:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int CW = C_AWIDTH + 1;

  if (!fifo_params_ok(C_WIDTH, C_DEPTH, C_AWIDTH, C_AFULL_THRESH, C_AEMPTY_THRESH, C_FWFT)) begin : g_param_err
    $error("ddr4_axi_sync_fifo: illegal parameter combination");
  end

  logic [C_WIDTH-1:0]  mem [C_DEPTH];
  logic [C_AWIDTH-1:0] wr_ptr;
  logic [C_AWIDTH-1:0] rd_ptr;
  logic                rd_acc;
  logic                wr_acc;

  // Flags come only from the count register, keeping inputs off the flag paths.
  assign empty   = (count == '0);
  assign full    = (count == CW'(C_DEPTH));
  assign a_full  = (count >= CW'(C_AFULL_THRESH));
  assign a_empty = (count <= CW'(C_AEMPTY_THRESH));

  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  ddr4_axi_fifo_ptr #(.C_DEPTH(C_DEPTH), .C_AWIDTH(C_AWIDTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_acc),
    .ptr   (wr_ptr)
  );

  ddr4_axi_fifo_ptr #(.C_DEPTH(C_DEPTH), .C_AWIDTH(C_AWIDTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_acc),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc && !rd_acc) begin
        count <= count + CW'(1);
      end else if (rd_acc && !wr_acc) begin
        count <= count - CW'(1);
      end
      overflow  <= wr_en & ~wr_acc;
      underflow <= rd_en & empty;
    end
  end

  if (C_FWFT == C_FWFT_MODE) begin : g_fwft
    assign dout = mem[rd_ptr];
  end else begin : g_std
    logic [C_WIDTH-1:0] dout_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else if (rd_acc) begin
        dout_q <= mem[rd_ptr];
      end
    end
    assign dout = dout_q;
  end

endmodule

// File: tb/tb_ddr4_axi_sync_fifo.sv
// Directed bench for ddr4_axi_sync_fifo: depth-5 FWFT instance (a) and depth-5 standard-read instance (b).
module tb_ddr4_axi_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       wr_a = 1'b0, rd_a = 1'b0;
  logic [7:0] din_a = '0, dout_a;
  logic       full_a, afull_a, empty_a, aempty_a, ovf_a, udf_a;
  logic [3:0] cnt_a;

  logic       wr_b = 1'b0, rd_b = 1'b0;
  logic [7:0] din_b = '0, dout_b;
  logic       full_b, afull_b, empty_b, aempty_b, ovf_b, udf_b;
  logic [3:0] cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ddr4_axi_sync_fifo #(.C_WIDTH(8), .C_DEPTH(5), .C_AWIDTH(3), .C_FWFT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_a), .din(din_a), .rd_en(rd_a), .dout(dout_a),
    .full(full_a), .a_full(afull_a), .empty(empty_a), .a_empty(aempty_a),
    .count(cnt_a), .overflow(ovf_a), .underflow(udf_a)
  );

  ddr4_axi_sync_fifo #(.C_WIDTH(8), .C_DEPTH(5), .C_AWIDTH(3), .C_FWFT(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_b), .din(din_b), .rd_en(rd_b), .dout(dout_b),
    .full(full_b), .a_full(afull_b), .empty(empty_b), .a_empty(aempty_b),
    .count(cnt_b), .overflow(ovf_b), .underflow(udf_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    check("rst_cnt", 32'(cnt_a), 0);
    check("rst_empty", 32'(empty_a), 1);
    check("rst_aempty", 32'(aempty_a), 1);
    check("rst_full", 32'(full_a), 0);
    check("rst_afull", 32'(afull_a), 0);
    check("rst_ovf", 32'(ovf_a), 0);
    check("rst_udf", 32'(udf_a), 0);
    check("rst_dout_b", 32'(dout_b), 0);
    rst_n = 1'b1;

    // Fill 0x01..0x05.
    for (int i = 1; i <= 5; i++) begin
      wr_a = 1'b1; din_a = 8'(i);
      tick();
      check("fill_cnt", 32'(cnt_a), 32'(i));
      check("fill_full", 32'(full_a), (i == 5) ? 1 : 0);
      check("fill_afull", 32'(afull_a), (i >= 3) ? 1 : 0);
      check("fill_aempty", 32'(aempty_a), (i <= 1) ? 1 : 0);
      check("fill_head", 32'(dout_a), 32'h01);
    end
    wr_a = 1'b0;

    // Drain; FWFT data is visible before rd_en.
    for (int i = 1; i <= 5; i++) begin
      check("drain_dout", 32'(dout_a), 32'(i));
      rd_a = 1'b1;
      tick();
      check("drain_cnt", 32'(cnt_a), 32'(5 - i));
    end
    rd_a = 1'b0;
    check("drain_empty", 32'(empty_a), 1);
    check("drain_udf", 32'(udf_a), 0);

    // Interleaved pairs across several pointer wraps.
    for (int k = 0; k < 12; k++) begin
      wr_a = 1'b1; din_a = 8'(8'h10 + k);
      tick();
      wr_a = 1'b0;
      check("wrap_cnt1", 32'(cnt_a), 1);
      check("wrap_dout", 32'(dout_a), 32'(8'h10 + k));
      rd_a = 1'b1;
      tick();
      rd_a = 1'b0;
      check("wrap_cnt0", 32'(cnt_a), 0);
      check("wrap_err", {30'b0, ovf_a, udf_a}, 0);
    end

    // Overflow at full, then simultaneous read+write at full.
    for (int i = 0; i < 5; i++) begin
      wr_a = 1'b1; din_a = 8'(8'h21 + i);
      tick();
    end
    din_a = 8'hEE;
    tick();
    wr_a = 1'b0;
    check("ovf_pulse", 32'(ovf_a), 1);
    check("ovf_cnt", 32'(cnt_a), 5);
    tick();
    check("ovf_clear", 32'(ovf_a), 0);
    check("full_head", 32'(dout_a), 32'h21);
    wr_a = 1'b1; rd_a = 1'b1; din_a = 8'h26;
    tick();
    wr_a = 1'b0; rd_a = 1'b0;
    check("full_rw_cnt", 32'(cnt_a), 5);
    check("full_rw_ovf", 32'(ovf_a), 0);
    for (int i = 0; i < 5; i++) begin
      check("full_rw_order", 32'(dout_a), 32'(8'h22 + i));
      rd_a = 1'b1;
      tick();
    end
    rd_a = 1'b0;
    check("full_rw_empty", 32'(empty_a), 1);

    // Underflow on empty, then write+read on empty.
    rd_a = 1'b1;
    tick();
    rd_a = 1'b0;
    check("udf_pulse", 32'(udf_a), 1);
    check("udf_cnt", 32'(cnt_a), 0);
    tick();
    check("udf_clear", 32'(udf_a), 0);
    wr_a = 1'b1; rd_a = 1'b1; din_a = 8'hAA;
    tick();
    wr_a = 1'b0; rd_a = 1'b0;
    check("wre_cnt", 32'(cnt_a), 1);
    check("wre_udf", 32'(udf_a), 1);
    check("wre_dout", 32'(dout_a), 32'hAA);
    rd_a = 1'b1;
    tick();
    rd_a = 1'b0;
    check("wre_empty", 32'(empty_a), 1);

    // Standard read mode.
    wr_b = 1'b1; din_b = 8'h33;
    tick();
    din_b = 8'h44;
    tick();
    wr_b = 1'b0;
    check("std_idle_dout", 32'(dout_b), 0);
    rd_b = 1'b1;
    tick();
    rd_b = 1'b0;
    check("std_dout1", 32'(dout_b), 32'h33);
    check("std_cnt1", 32'(cnt_b), 1);
    tick();
    tick();
    check("std_hold", 32'(dout_b), 32'h33);
    rd_b = 1'b1;
    tick();
    rd_b = 1'b0;
    check("std_dout2", 32'(dout_b), 32'h44);
    check("std_empty", 32'(empty_b), 1);

    // Mid-burst reset: a at count 3, b at count 3 with a loaded dout register.
    for (int k = 0; k < 4; k++) begin
      wr_a = (k < 3); din_a = 8'(8'h61 + k);
      wr_b = 1'b1; din_b = 8'(8'h51 + k);
      tick();
    end
    wr_a = 1'b0; wr_b = 1'b0;
    rd_b = 1'b1;
    tick();
    rd_b = 1'b0;
    check("pre_rst_cnt_a", 32'(cnt_a), 3);
    check("pre_rst_dout_b", 32'(dout_b), 32'h51);
    wr_a = 1'b1; din_a = 8'h99;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_empty", 32'(empty_a), 1);
    check("arst_cnt", 32'(cnt_a), 0);
    check("arst_dout_b", 32'(dout_b), 0);
    check("arst_cnt_b", 32'(cnt_b), 0);
    tick();
    check("rst_ignore_wr", 32'(cnt_a), 0);
    din_a = 8'h77; wr_b = 1'b1; din_b = 8'h77;
    rst_n = 1'b1;
    tick();
    wr_a = 1'b0; wr_b = 1'b0;
    check("post_rst_cnt", 32'(cnt_a), 1);
    check("post_rst_dout", 32'(dout_a), 32'h77);
    rd_a = 1'b1; rd_b = 1'b1;
    tick();
    rd_a = 1'b0; rd_b = 1'b0;
    check("post_rst_empty", 32'(empty_a), 1);
    check("post_rst_dout_b", 32'(dout_b), 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
